// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states,
// the default access wait limit and the misalignment rule.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // The reserved size encoding is handled like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    if (size == SZ_BYTE)
      return 1'b0;
    else if (size == SZ_HALF)
      return offset[0];
    else
      return offset != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store byte enables and replicated write
// data, plus load byte/half extraction with zero or sign extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] store_in,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte  = rdata[{offset, 3'b000} +: 8];
    sel_half  = offset[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'b1111;
    wdata     = store_in;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_in[7:0]}};
        load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_in[15:0]}};
        load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data memory req/ack access with lane steering, stalls
// upstream while an access is outstanding. Define MEM_STAGE_TIMEOUT_EN to abort
// accesses that see no dmem_ack within MAX_WAIT cycles (pulses bus_err).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [4:0]        write_addr_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [1:0]        MemToReg_in,
  input  logic              RegWrite_in,
  output logic [4:0]        write_addr_out,
  output logic [31:0]       mem_data_out,
  output logic [1:0]        MemToReg_out,
  output logic              RegWrite_out,
  output logic              misalign_exc,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  state_t      state;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [4:0]  lat_waddr;
  logic [1:0]  lat_m2r;
  logic        lat_rw;
  logic        accept;
  logic        is_mem;
  logic        timeout;
  logic [1:0]  lane_off;
  logic [1:0]  lane_size;
  logic        lane_signed;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign in_ready = reset & (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = MemRead | MemWrite;

  // Steering uses the incoming instruction when idle and the latched access otherwise.
  assign lane_off    = (state == IDLE) ? alu_result[1:0] : lat_off;
  assign lane_size   = (state == IDLE) ? mem_size        : lat_size;
  assign lane_signed = (state == IDLE) ? mem_signed      : lat_signed;

  mem_lane_align u_align (
    .offset    (lane_off),
    .size      (lane_size),
    .sign_ext  (lane_signed),
    .store_in  (store_data),
    .rdata     (dmem_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (lane_load)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset || state != ACCESS)
      wait_cnt <= '0;
    else if (!dmem_ack)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // The current cycle is the MAX_WAIT-th one without ack; an ack here still wins.
  assign timeout = (state == ACCESS) && !dmem_ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      write_addr_out <= '0;
      mem_data_out   <= '0;
      MemToReg_out   <= '0;
      RegWrite_out   <= 1'b0;
      misalign_exc   <= 1'b0;
      bus_err        <= 1'b0;
      lat_off        <= '0;
      lat_size       <= '0;
      lat_signed     <= 1'b0;
      lat_waddr      <= '0;
      lat_m2r        <= '0;
      lat_rw         <= 1'b0;
    end else begin
      write_addr_out <= '0;
      mem_data_out   <= '0;
      MemToReg_out   <= '0;
      RegWrite_out   <= 1'b0;
      misalign_exc   <= 1'b0;
      bus_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              write_addr_out <= write_addr_in;
              mem_data_out   <= alu_result;
              MemToReg_out   <= MemToReg_in;
              RegWrite_out   <= RegWrite_in;
            end else if (is_misaligned(mem_size, alu_result[1:0])) begin
              misalign_exc <= 1'b1;
            end else begin
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
              dmem_be    <= lane_be;
              dmem_wdata <= MemWrite ? lane_wdata : 32'h0;
              lat_off    <= alu_result[1:0];
              lat_size   <= mem_size;
              lat_signed <= mem_signed;
              lat_waddr  <= write_addr_in;
              lat_m2r    <= MemToReg_in;
              lat_rw     <= RegWrite_in;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack || timeout) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            if (dmem_ack) begin
              RegWrite_out <= lat_rw;
              if (!dmem_we) begin
                write_addr_out <= lat_waddr;
                MemToReg_out   <= lat_m2r;
                mem_data_out   <= lane_load;
              end
            end else begin
              bus_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It accepts one instruction per cycle from EX/MEM. Loads and stores go to the data memory over a req/ack handshake, with byte-lane steering, load sign/zero extension and misalignment detection. Each instruction is presented as one registered result (write address, data, WB control) to MEM/WB. While a memory access is outstanding it stalls the upstream stages and emits bubbles downstream.

## Interface
Parameters:
- ADDR_W, 32, data address width
- MAX_WAIT, 15, cycles without dmem_ack before an access is aborted (used only with timeout enabled)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  stage accepts an instruction this cycle; low means the pipeline stalls
- alu_result  in  32  effective address, or the ALU value for non-memory instructions
- store_data  in  32  rt value for stores
- write_addr_in  in  5  destination register
- MemRead, MemWrite  in  1 each  access type
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_signed  in  1  sign-extend loads
- MemToReg_in  in  2  WB mux select, passed through
- RegWrite_in  in  1  WB enable, passed through
- write_addr_out  out  5  to MEM/WB
- mem_data_out  out  32  load data or alu_result, to MEM/WB
- MemToReg_out  out  2  to MEM/WB
- RegWrite_out  out  1  to MEM/WB; 0 for every bubble
- misalign_exc  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on an aborted access (timeout build only, otherwise tied 0)
- dmem_req  out  1  access request
- dmem_we  out  1  write access
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_ack  in  1  access complete; read data valid in the same cycle
- dmem_rdata  in  32  read word

## Operation
- FSM states: IDLE, ACCESS. in_ready = reset & (state == IDLE).
- IDLE, accept (in_valid & in_ready):
  - No MemRead/MemWrite: register the pass-through. mem_data_out = alu_result; WB controls copied.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0): no request issued. Output is a bubble with RegWrite_out=0. misalign_exc pulses.
  - Otherwise: latch the request fields and go to ACCESS. Output is a bubble.
- IDLE with no accepted instruction: output is a bubble.
- ACCESS:
  - dmem_req=1 with stable addr, be, we and wdata until ack.
  - On dmem_ack: a load registers the extracted data; a store registers a bubble with RegWrite_out forced to RegWrite_in as latched (normally 0). Return to IDLE.
- Byte lanes are little-endian, selected by addr[1:0].
  - Store byte: be=0001<<addr[1:0], data replicated to all four lanes.
  - Store half: be=0011 or 1100, data replicated to both halves.
  - Store word: be=1111.
- Load extraction picks the addressed byte or half, then applies zero extension, or sign extension when mem_signed=1.
- MemRead and MemWrite both set: treated as a store.
- dmem_ack while in IDLE is ignored.

## Timing
- Non-memory instruction: accepted at edge N, result on the outputs after edge N. Throughput is 1 per cycle.
- Memory access:
  - Accepted at edge N. dmem_req is high from after edge N.
  - With ack sampled at edge N+k (k≥1), the result is valid after edge N+k.
  - in_ready is low during cycles N+1..N+k and high again after edge N+k.
- Every output holds for exactly one cycle; MEM/WB captures every cycle.
- Reset (reset=0 at an edge) sets:
  - state=IDLE;
  - all outputs 0, including dmem_req, exc and err;
  - in_ready=0 while reset is low.
- Reset mid-ACCESS drops dmem_req at that edge, and the pending result is discarded.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A wait counter (width ceil(log2(MAX_WAIT+1))) clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When the counter reaches MAX_WAIT with no ack: drop req, pulse bus_err, emit a bubble, return to IDLE.
  - Ack in the same cycle as the limit wins.
- Undefined: no counter; ACCESS waits indefinitely; bus_err is constant 0.

## Structure
- Package mem_stage_pkg holds: mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state constants, and the default for MAX_WAIT.
- One combinational sub-module, mem_lane_align, produces store be/wdata and load extract/extend from addr[1:0], size and signed.

## Test plan
- ALU op: alu_result=0x1234, RegWrite_in=1, write_addr_in=5 -> next cycle mem_data_out=0x1234, write_addr_out=5, RegWrite_out=1, in_ready stays 1.
- Signed byte load at 0x1003, rdata=0x80FFFFFF, ack after 2 cycles -> dmem_addr=0x1000, be=1000, mem_data_out=0xFFFFFF80, in_ready low for 2 cycles.
- Half store 0xBEEF to 0x2002 -> dmem_we=1, be=1100, wdata=0xBEEFBEEF, RegWrite_out=0.
- Word load at 0x3001 -> no dmem_req, misalign_exc one pulse, RegWrite_out=0.
- Reset low during ACCESS, then late ack -> req=0 at the reset edge, all outputs 0, late ack ignored.
- Timeout build, MAX_WAIT=15, no ack -> req drops after 15 ACCESS cycles, bus_err one pulse, in_ready returns to 1.
